// File: rtl/spi_apb_pkg.sv
// Shared definitions for the SPI-over-APB byte sequencer: register map,
// FSM states and the per-transaction step encoding.
package spi_apb_pkg;

    localparam logic [2:0] ADDR_CR1_DEF = 3'd0;
    localparam logic [2:0] ADDR_CR2_DEF = 3'd1;
    localparam logic [2:0] ADDR_BR_DEF  = 3'd2;
    localparam logic [2:0] ADDR_SR_DEF  = 3'd3;
    localparam logic [2:0] ADDR_DR_DEF  = 3'd5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_WAIT_IRQ,
        ST_DONE
    } state_t;

    typedef logic [2:0] step_t;

    localparam step_t STEP_WR_CR1  = 3'd0;
    localparam step_t STEP_WR_CR2  = 3'd1;
    localparam step_t STEP_WR_BR   = 3'd2;
    localparam step_t STEP_WR_DR   = 3'd3;
    localparam step_t STEP_WAIT    = 3'd4;
    localparam step_t STEP_RD_SR   = 3'd5;
    localparam step_t STEP_RD_DR   = 3'd6;

    function automatic logic step_is_write(step_t s);
        return s <= STEP_WR_DR;
    endfunction

endpackage

// File: rtl/spi_apb_sequencer.sv
// APB master that runs one full SPI byte exchange (config, tx, irq wait, SR/DR read).
// Optional build macro SPI_SEQ_CFG_CACHE_EN skips the config writes when unchanged.
module spi_apb_sequencer
    import spi_apb_pkg::*;
#(
    parameter int         TIMEOUT_CYCLES = 4096,
    parameter logic [2:0] ADDR_CR1       = ADDR_CR1_DEF,
    parameter logic [2:0] ADDR_CR2       = ADDR_CR2_DEF,
    parameter logic [2:0] ADDR_BR        = ADDR_BR_DEF,
    parameter logic [2:0] ADDR_SR        = ADDR_SR_DEF,
    parameter logic [2:0] ADDR_DR        = ADDR_DR_DEF
) (
    input  logic       PCLK,
    input  logic       PRESET,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [7:0] req_cr1_i,
    input  logic [7:0] req_cr2_i,
    input  logic [7:0] req_br_i,
    input  logic [7:0] req_txdata_i,
    output logic       rsp_valid_o,
    output logic [7:0] rsp_rxdata_o,
    output logic [7:0] rsp_status_o,
    output logic       rsp_err_o,
    output logic [2:0] PADDR_o,
    output logic       PSEL_o,
    output logic       PENABLE_o,
    output logic       PWRITE_o,
    output logic [7:0] PWDATA_o,
    input  logic [7:0] PRDATA_i,
    input  logic       PREADY_i,
    input  logic       PSLVERR_i,
    input  logic       spi_interrupt_request_i
);

    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state;
    step_t         step;
    logic [CW-1:0] tmo_cnt;
    logic [7:0]    cr1_q, cr2_q, br_q, tx_q;

    logic          cache_hit;
    step_t         start_step;
    step_t         setup_step;
    logic [7:0]    setup_wdata;
    logic          go_setup;
    logic          abort;

    function automatic logic [2:0] addr_of(step_t s);
        case (s)
            STEP_WR_CR1: return ADDR_CR1;
            STEP_WR_CR2: return ADDR_CR2;
            STEP_WR_BR:  return ADDR_BR;
            STEP_RD_SR:  return ADDR_SR;
            default:     return ADDR_DR;
        endcase
    endfunction

    function automatic logic [7:0] wdata_of(step_t s, logic [7:0] c1, logic [7:0] c2,
                                            logic [7:0] b, logic [7:0] t);
        case (s)
            STEP_WR_CR1: return c1;
            STEP_WR_CR2: return c2;
            STEP_WR_BR:  return b;
            STEP_WR_DR:  return t;
            default:     return 8'h00;
        endcase
    endfunction

`ifdef SPI_SEQ_CFG_CACHE_EN
    logic        cache_vld;
    logic [23:0] cache_cfg;

    assign cache_hit = cache_vld && (cache_cfg == {req_cr1_i, req_cr2_i, req_br_i});

    // Only a clean completion proves the slave holds this configuration.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            cache_vld <= 1'b0;
        end else if (state == ST_DONE) begin
            if (rsp_err_o) begin
                cache_vld <= 1'b0;
            end else begin
                cache_vld <= 1'b1;
                cache_cfg <= {cr1_q, cr2_q, br_q};
            end
        end
    end
`else
    assign cache_hit = 1'b0;
`endif

    assign start_step  = cache_hit ? STEP_WR_DR : STEP_WR_CR1;
    assign req_ready_o = (state == ST_IDLE) && !PRESET;

    // Next SETUP target: from IDLE the request fields are not registered yet.
    always_comb begin
        setup_step = STEP_RD_SR;
        if (state == ST_IDLE)
            setup_step = start_step;
        else if (state == ST_ACCESS)
            setup_step = step + 3'd1;
        if (state == ST_IDLE)
            setup_wdata = wdata_of(setup_step, req_cr1_i, req_cr2_i, req_br_i, req_txdata_i);
        else
            setup_wdata = wdata_of(setup_step, cr1_q, cr2_q, br_q, tx_q);
    end

    always_comb begin
        go_setup = 1'b0;
        abort    = 1'b0;
        case (state)
            ST_IDLE:     go_setup = req_valid_i;
            ST_ACCESS: begin
                abort    = PREADY_i ? PSLVERR_i : (tmo_cnt == TO_LAST);
                go_setup = PREADY_i && !PSLVERR_i &&
                           (step != STEP_WR_DR) && (step != STEP_RD_DR);
            end
            ST_WAIT_IRQ: begin
                go_setup = spi_interrupt_request_i;
                abort    = !spi_interrupt_request_i && (tmo_cnt == TO_LAST);
            end
            default: ;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state        <= ST_IDLE;
            step         <= STEP_WR_CR1;
            tmo_cnt      <= '0;
            cr1_q        <= '0;
            cr2_q        <= '0;
            br_q         <= '0;
            tx_q         <= '0;
            PADDR_o      <= '0;
            PSEL_o       <= 1'b0;
            PENABLE_o    <= 1'b0;
            PWRITE_o     <= 1'b0;
            PWDATA_o     <= '0;
            rsp_valid_o  <= 1'b0;
            rsp_rxdata_o <= '0;
            rsp_status_o <= '0;
            rsp_err_o    <= 1'b0;
        end else if (abort) begin
            PADDR_o     <= '0;
            PSEL_o      <= 1'b0;
            PENABLE_o   <= 1'b0;
            PWRITE_o    <= 1'b0;
            PWDATA_o    <= '0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= 1'b1;
            tmo_cnt     <= '0;
            state       <= ST_DONE;
        end else begin
            rsp_valid_o <= 1'b0;
            if (go_setup) begin
                step      <= setup_step;
                PSEL_o    <= 1'b1;
                PENABLE_o <= 1'b0;
                PADDR_o   <= addr_of(setup_step);
                PWRITE_o  <= step_is_write(setup_step);
                PWDATA_o  <= setup_wdata;
                tmo_cnt   <= '0;
                state     <= ST_SETUP;
            end
            case (state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        cr1_q        <= req_cr1_i;
                        cr2_q        <= req_cr2_i;
                        br_q         <= req_br_i;
                        tx_q         <= req_txdata_i;
                        rsp_rxdata_o <= '0;
                        rsp_status_o <= '0;
                        rsp_err_o    <= 1'b0;
                    end
                end
                ST_SETUP: begin
                    PENABLE_o <= 1'b1;
                    tmo_cnt   <= '0;
                    state     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY_i) begin
                        if (step == STEP_RD_SR) rsp_status_o <= PRDATA_i;
                        if (step == STEP_RD_DR) rsp_rxdata_o <= PRDATA_i;
                        if (step == STEP_WR_DR || step == STEP_RD_DR) begin
                            PADDR_o   <= '0;
                            PSEL_o    <= 1'b0;
                            PENABLE_o <= 1'b0;
                            PWRITE_o  <= 1'b0;
                            PWDATA_o  <= '0;
                            tmo_cnt   <= '0;
                            if (step == STEP_WR_DR) begin
                                step  <= STEP_WAIT;
                                state <= ST_WAIT_IRQ;
                            end else begin
                                rsp_valid_o <= 1'b1;
                                state       <= ST_DONE;
                            end
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_WAIT_IRQ: begin
                    if (!spi_interrupt_request_i) tmo_cnt <= tmo_cnt + 1'b1;
                end
                ST_DONE: begin
                    tmo_cnt <= '0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_apb_sequencer.md
Name: spi_apb_sequencer

Overview:
APB master that sequences one complete SPI byte transaction on the APB-SPI slave block on behalf of a simple host request interface.
- Per request: writes CR1, CR2, BR and the DR tx byte; waits for the SPI interrupt; reads SR and then DR; returns the rx byte.
- Sits between a host/CPU-side command port and the APB-SPI slave.
- Replaces hand-sequenced APB traffic.

Parameters:
TIMEOUT_CYCLES, 4096, max cycles spent waiting for PREADY_i or spi_interrupt_request_i before abort
ADDR_CR1, 3'd0, CR1 register address
ADDR_CR2, 3'd1, CR2 register address
ADDR_BR, 3'd2, baud-rate register address
ADDR_SR, 3'd3, status register address
ADDR_DR, 3'd5, data register address

Ports:
PCLK  input  1  clock, rising edge
PRESET  input  1  synchronous reset, active-high
req_valid_i  input  1  host request valid
req_ready_o  output  1  sequencer idle, can accept request
req_cr1_i  input  8  CR1 value
req_cr2_i  input  8  CR2 value
req_br_i  input  8  BR value
req_txdata_i  input  8  byte to transmit
rsp_valid_o  output  1  one-cycle pulse, response valid
rsp_rxdata_o  output  8  received byte (DR read)
rsp_status_o  output  8  SR value read
rsp_err_o  output  1  transaction aborted (PSLVERR or timeout); valid with rsp_valid_o
PADDR_o  output  3  APB address
PSEL_o  output  1  APB select
PENABLE_o  output  1  APB enable
PWRITE_o  output  1  APB write
PWDATA_o  output  8  APB write data
PRDATA_i  input  8  APB read data
PREADY_i  input  1  APB ready
PSLVERR_i  input  1  APB slave error
spi_interrupt_request_i  input  1  SPI transfer-complete interrupt; level, cleared by slave on SR read

Behaviour:
- Reset (PRESET=1 at a rising edge):
  - All APB outputs = 0; rsp_valid_o = 0; rsp_rxdata_o = rsp_status_o = 0; rsp_err_o = 0.
  - State = IDLE; step = 0; timeout counter = 0.
  - Reset mid-transfer drops PSEL_o the next edge; no completion of the in-flight transfer.
- req_ready_o = 1 only in IDLE and not in reset. Request captured (cr1/cr2/br/tx into regs) on req_valid_i && req_ready_o. req_valid_i is ignored while busy.
- Step list:
  - 0 WR CR1, 1 WR CR2, 2 WR BR, 3 WR DR(tx)
  - 4 WAIT_IRQ
  - 5 RD SR, 6 RD DR
- FSM states and transitions:
  - IDLE -> SETUP on accept.
  - SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA set for the current step.
  - ACCESS: PSEL=1, PENABLE=1, address/data held stable. Stays until PREADY_i=1.
    - On PREADY_i && PSLVERR_i -> DONE with err.
    - On PREADY_i && !PSLVERR_i: read steps capture PRDATA_i; advance step; step 3 -> WAIT_IRQ, step 6 -> DONE, else -> SETUP.
  - WAIT_IRQ: APB outputs 0. Sampled only here. spi_interrupt_request_i=1 -> SETUP (step 5).
  - DONE (1 cycle): rsp_valid_o=1 with data/status/err -> IDLE.
- Back-to-back APB transfers: PSEL_o drops to 0 for no cycle between steps; PENABLE_o returns to 0 in each SETUP.
- Timeout:
  - Counter clears on every state change and increments in ACCESS and WAIT_IRQ.
  - Reaching TIMEOUT_CYCLES-1 -> DONE with rsp_err_o=1; PSEL/PENABLE dropped.
  - Counter width $clog2(TIMEOUT_CYCLES).
- Latency with PREADY_i tied 1:
  - Accept at cycle T. CR1 SETUP at T+1. DR-write ACCESS at T+8. WAIT_IRQ from T+9.
  - IRQ first high at cycle W -> SR SETUP W+1, DR read ACCESS W+4, rsp_valid_o at W+5.
- IRQ already high on WAIT_IRQ entry: leave WAIT_IRQ on the first WAIT_IRQ cycle.
- On error: rsp_rxdata_o/rsp_status_o carry any values captured so far; uncaptured fields = 0.

Optional Feature:
SPI_SEQ_CFG_CACHE_EN
- Defined:
  - Keeps last successfully written {CR1,CR2,BR} plus a cache-valid bit.
  - Cache-valid is cleared on reset and on any error; it is set and updated in DONE without error.
  - On accept with cache valid and equal config, step starts at 3, so DR write SETUP is at T+1.
- Undefined: always starts at step 0; no cache registers.

Decomposition:
- Shared package spi_apb_pkg:
  - Register address constants.
  - State enum (IDLE, SETUP, ACCESS, WAIT_IRQ, DONE).
  - Step encoding (3 bits).
- Single module. An optional sub-module apb_master_if (SETUP/ACCESS/PREADY/PSLVERR handling, request/done handshake) is natural and reusable.

Test Plan:
- Reset, then request cr1=F5, cr2=C4, br=01, tx=AA, PREADY=1, IRQ at W, PRDATA SR=80/DR=55 -> APB writes 0:F5, 1:C4, 2:01, 5:AA in order; reads 3, then 5; rsp_valid at W+5 with rx=55, status=80, err=0.
- PREADY_i low 3 cycles on the BR write -> PENABLE held and PADDR=2/PWDATA=01 stable 4 cycles; sequence otherwise unchanged.
- PSLVERR_i=1 on the CR2 write -> no further APB transfers; rsp_valid with err=1, rx=0, status=0; req_ready_o=1 next cycle.
- IRQ never asserted, TIMEOUT_CYCLES=16 -> rsp_err_o=1 sixteen cycles after WAIT_IRQ entry; no SR/DR reads.
- PRESET pulsed during the DR-write ACCESS -> PSEL_o/PENABLE_o = 0 next edge, no rsp_valid; a fresh request then runs from step 0.
- SPI_SEQ_CFG_CACHE_EN: two identical requests -> second issues only the DR write and the two reads; a third request with changed br -> full sequence.
